hazard_forward_unit: RTL and testbench

// - Parametrised successor to the ID-stage control unit's hazard and forwarding logic.
// - Holds a registered scoreboard of in-flight register writes for FWD_STAGES stages after ID.
// - Produces per-operand forward selects, load-use and multi-cycle (MDU) stalls, and redirect flushes.
// - Sits beside the decoder in ID. Its outputs drive the FWD A/B muxes and the PC, IF/ID and ID/EXE registers.

---
 rtl/riscv_ctrl_pkg.sv | 33 +++
 rtl/hazard_scoreboard.sv | 37 +++
 rtl/hazard_forward_unit.sv | 147 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared constants and types for the ID-stage hazard/forward logic
//
// Purpose:
//   Forward-select encodings, the scoreboard entry layout and the FSM state
//   constants used by hazard_forward_unit and hazard_scoreboard.
// Contents:
//   FWD_RF / fwd_stg(k)   operand select: 0 = regfile, k+1 = stage k
//   SB_RD_W               stored rd width (REG_AW must not exceed it)
//   sb_entry_t            {vld, rd, is_load, is_mdu}
//   S_RUN / S_MDU_WAIT    FSM state encodings
package riscv_ctrl_pkg;

  localparam int FWD_RF = 0;

  function automatic int fwd_stg(input int k);
    return k + 1;
  endfunction

  // rd is stored at a fixed width so the entry type does not depend on REG_AW;
  // narrower addresses are zero-extended on entry.
  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               vld;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
    logic               is_mdu;
  } sb_entry_t;

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_MDU_WAIT = 1'b1;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shift register of in-flight register writes after ID
//
// Purpose:
//   Entry 0 is EXE, entry FWD_STAGES-1 is the last forwardable stage and
//   retires on the next shift. The whole pipe holds while freeze is high.
// Ports:
//   clk      in   core clock, rising edge
//   rstn     in   asynchronous active-low reset, clears all entries
//   freeze   in   hold every entry this cycle
//   issue    in   ID instruction enters EXE; otherwise a bubble enters
//   entry_in in   entry describing the ID instruction
//   entries  out  current scoreboard contents, index 0 = EXE
module hazard_scoreboard
  import riscv_ctrl_pkg::*;
#(
  parameter int FWD_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         freeze,
  input  logic                         issue,
  input  sb_entry_t                    entry_in,
  output sb_entry_t [FWD_STAGES-1:0]   entries
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      entries <= '0;
    end else if (!freeze) begin
      entries[0] <= issue ? entry_in : '0;
      for (int k = 1; k < FWD_STAGES; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - ID-stage forward select, load-use/MDU stall and redirect flush
//
// Purpose:
//   Tracks in-flight writes in a scoreboard, picks the youngest forwarding
//   source per operand, and drives PC / IF-ID / ID-EXE control.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   dValid                    ID holds a real instruction
//   dRs1, dRs2, dUseRs1/2     ID sources and their use flags
//   dRd, dWreg                ID destination and write enable
//   dIsLoad, dIsMdu           ID instruction class
//   exeRedirect               taken branch/jump resolved in EXE
//   qaSel, qbSel              0 = regfile, k+1 = forward from stage k
//   pcStall, ifidStall        hold PC / IF-ID
//   ifidFlush, idexBubble     squash IF-ID / insert NOP into ID-EXE
//   mduBusy                   mul/div occupying EXE
module hazard_forward_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int MDU_LAT    = 4,
  parameter int SELW       = $clog2(FWD_STAGES + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              dValid,
  input  logic [REG_AW-1:0] dRs1,
  input  logic [REG_AW-1:0] dRs2,
  input  logic              dUseRs1,
  input  logic              dUseRs2,
  input  logic [REG_AW-1:0] dRd,
  input  logic              dWreg,
  input  logic              dIsLoad,
  input  logic              dIsMdu,
  input  logic              exeRedirect,
  output logic [SELW-1:0]   qaSel,
  output logic [SELW-1:0]   qbSel,
  output logic              pcStall,
  output logic              ifidStall,
  output logic              ifidFlush,
  output logic              idexBubble,
  output logic              mduBusy
);

  localparam int CNTW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

  logic [0:0]                 state, state_nxt;
  logic [CNTW-1:0]            mdu_cnt, mdu_cnt_nxt;
  sb_entry_t [FWD_STAGES-1:0] sb;
  sb_entry_t                  entry_in;
  logic [SELW-1:0]            qa_sel, qb_sel;
  logic                       qa_nr, qb_nr;
  logic                       frozen, load_use, issue;

  // A matched producer whose result is not yet available at its stage.
  function automatic logic not_ready(input sb_entry_t e, input int k, input logic [0:0] st);
    return (e.is_load && (k < LOAD_LAT)) || (e.is_mdu && (st == S_MDU_WAIT) && (k == 0));
  endfunction

  // Iterating from the oldest stage down lets the youngest match overwrite.
  always_comb begin
    qa_sel = SELW'(FWD_RF);
    qb_sel = SELW'(FWD_RF);
    qa_nr  = 1'b0;
    qb_nr  = 1'b0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (dUseRs1 && sb[k].vld && (sb[k].rd == SB_RD_W'(dRs1))) begin
        qa_sel = SELW'(fwd_stg(k));
        qa_nr  = not_ready(sb[k], k, state);
      end
      if (dUseRs2 && sb[k].vld && (sb[k].rd == SB_RD_W'(dRs2))) begin
        qb_sel = SELW'(fwd_stg(k));
        qb_nr  = not_ready(sb[k], k, state);
      end
    end
  end

  assign frozen   = (state == S_MDU_WAIT);
  assign load_use = qa_nr | qb_nr;
  assign issue    = dValid & ~frozen & ~load_use & ~exeRedirect;

  always_comb begin
    entry_in         = '0;
    entry_in.vld     = dWreg & (dRd != '0);
    entry_in.rd      = SB_RD_W'(dRd);
    entry_in.is_load = dIsLoad;
    entry_in.is_mdu  = dIsMdu;
  end

  hazard_scoreboard #(
    .FWD_STAGES (FWD_STAGES)
  ) u_sb (
    .clk      (clk),
    .rstn     (rstn),
    .freeze   (frozen),
    .issue    (issue),
    .entry_in (entry_in),
    .entries  (sb)
  );

  always_comb begin
    state_nxt   = state;
    mdu_cnt_nxt = mdu_cnt;
    case (state)
      S_RUN: begin
        if (issue && dIsMdu && (MDU_LAT > 1)) begin
          state_nxt   = S_MDU_WAIT;
          mdu_cnt_nxt = CNTW'(MDU_LAT - 1);
        end
      end
      S_MDU_WAIT: begin
        mdu_cnt_nxt = mdu_cnt - CNTW'(1);
        if (mdu_cnt == CNTW'(1)) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_RUN;
      mdu_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= mdu_cnt_nxt;
    end
  end

  // Priority: frozen > redirect > load-use. Outputs are forced low in reset
  // so a live exeRedirect cannot leak a flush through.
  assign pcStall    = rstn & (frozen | (~exeRedirect & load_use));
  assign ifidStall  = pcStall;
  assign ifidFlush  = rstn & ~frozen & exeRedirect;
  assign idexBubble = rstn & ~frozen & (exeRedirect | load_use);
  assign mduBusy    = rstn & frozen;
  assign qaSel      = rstn ? qa_sel : '0;
  assign qbSel      = rstn ? qb_sel : '0;

  // The pipeline cannot resolve a branch while a mul/div owns EXE.
  a_no_redirect_in_mdu : assert property (@(posedge clk) disable iff (!rstn)
    !(frozen && exeRedirect));

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rstn;
  logic       dValid, dUseRs1, dUseRs2, dWreg, dIsLoad, dIsMdu, exeRedirect;
  logic [4:0] dRs1, dRs2, dRd;
  logic [1:0] qaSel, qbSel;
  logic       pcStall, ifidStall, ifidFlush, idexBubble, mduBusy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(
    .REG_AW(5), .FWD_STAGES(2), .LOAD_LAT(1), .MDU_LAT(4)
  ) dut (
    .clk(clk), .rstn(rstn), .dValid(dValid),
    .dRs1(dRs1), .dRs2(dRs2), .dUseRs1(dUseRs1), .dUseRs2(dUseRs2),
    .dRd(dRd), .dWreg(dWreg), .dIsLoad(dIsLoad), .dIsMdu(dIsMdu),
    .exeRedirect(exeRedirect),
    .qaSel(qaSel), .qbSel(qbSel), .pcStall(pcStall), .ifidStall(ifidStall),
    .ifidFlush(ifidFlush), .idexBubble(idexBubble), .mduBusy(mduBusy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic w, input logic ld, input logic md, input logic redir);
    dValid = v; dRs1 = rs1; dUseRs1 = u1; dRs2 = rs2; dUseRs2 = u2;
    dRd = rd; dWreg = w; dIsLoad = ld; dIsMdu = md; exeRedirect = redir;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) cyc();
  endtask

  task automatic chk_ctrl(input string tag, input int stall, input int flush,
                          input int bubble, input int busy);
    chk({tag, ".pcStall"}, int'(pcStall), stall);
    chk({tag, ".ifidStall"}, int'(ifidStall), stall);
    chk({tag, ".ifidFlush"}, int'(ifidFlush), flush);
    chk({tag, ".idexBubble"}, int'(idexBubble), bubble);
    chk({tag, ".mduBusy"}, int'(mduBusy), busy);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_ctrl("reset", 0, 0, 0, 0);
    chk("reset.qaSel", int'(qaSel), 0);
    chk("reset.qbSel", int'(qbSel), 0);
    rstn = 1'b1;
    cyc();

    // ALU chain: add x5 ; add x6,x5,x5 ; consumer of x5 one cycle later
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    @(negedge clk); chk_ctrl("alu.p", 0, 0, 0, 0);
    cyc();
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    @(negedge clk);
    chk("alu.qa1", int'(qaSel), 1);
    chk("alu.qb1", int'(qbSel), 1);
    chk_ctrl("alu.c", 0, 0, 0, 0);
    cyc();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alu.qa2", int'(qaSel), 2);
    chk("alu.qb2", int'(qbSel), 0);
    cyc();
    idle(2);

    // Load-use: lw x7 ; add x8,x7,x0
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    cyc();
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0, 0);
    @(negedge clk);
    chk_ctrl("lu.stall", 1, 0, 1, 0);
    chk("lu.qa1", int'(qaSel), 1);
    chk("lu.qb_x0", int'(qbSel), 0);
    cyc();
    @(negedge clk);
    chk_ctrl("lu.after", 0, 0, 0, 0);
    chk("lu.qa2", int'(qaSel), 2);
    cyc();
    // add x8 was issued after the stall, so it now sits in EXE
    drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("lu.x8_fwd", int'(qaSel), 1);
    cyc();
    idle(2);

    // Youngest wins: two writers of x9, then a consumer
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    cyc();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    cyc();
    drive(1, 9, 1, 9, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("yw.qa", int'(qaSel), 1);
    chk("yw.qb", int'(qbSel), 1);
    cyc();
    idle(2);
    // rd=x0 producers never match
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("x0.qa", int'(qaSel), 0);
    chk("x0.qb", int'(qbSel), 0);
    chk_ctrl("x0", 0, 0, 0, 0);
    cyc();
    idle(2);

    // MDU: mul x10 then dependent add x11,x10
    drive(1, 0, 0, 0, 0, 10, 1, 0, 1, 0);
    @(negedge clk); chk_ctrl("mdu.issue", 0, 0, 0, 0);
    cyc();
    drive(1, 10, 1, 0, 0, 11, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_ctrl($sformatf("mdu.wait%0d", i), 1, 0, 0, 1);
      cyc();
    end
    @(negedge clk);
    chk_ctrl("mdu.run", 0, 0, 0, 0);
    chk("mdu.qa", int'(qaSel), 1);
    cyc();
    idle(2);

    // Redirect and load-use in the same cycle
    drive(1, 0, 0, 0, 0, 12, 1, 1, 0, 0);
    cyc();
    drive(1, 12, 1, 0, 0, 13, 1, 0, 0, 1);
    @(negedge clk);
    chk_ctrl("rd.lu", 0, 1, 1, 0);
    cyc();
    // squashed add x13 must not be tracked; lw x12 is now in MEM
    drive(1, 13, 1, 12, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rd.qa_squashed", int'(qaSel), 0);
    chk("rd.qb", int'(qbSel), 2);
    chk_ctrl("rd.after", 0, 0, 0, 0);
    cyc();
    idle(2);

    // Reset in the middle of MDU_WAIT
    drive(1, 0, 0, 0, 0, 15, 1, 0, 1, 0);
    cyc();
    drive(1, 15, 1, 0, 0, 16, 1, 0, 0, 0);
    @(negedge clk); chk("rst.busy_before", int'(mduBusy), 1);
    #1 rstn = 1'b0; exeRedirect = 1'b1;
    #1;
    chk_ctrl("rst.mid", 0, 0, 0, 0);
    chk("rst.qa", int'(qaSel), 0);
    #1 rstn = 1'b1;
    drive(1, 0, 0, 0, 0, 14, 1, 0, 0, 0);
    #1;
    chk_ctrl("rst.release", 0, 0, 0, 0);
    cyc();
    drive(1, 14, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst.issue_fwd", int'(qaSel), 1);
    chk_ctrl("rst.run", 0, 0, 0, 0);
    cyc();
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
